// File: rtl/i2c_wb_sequencer.sv
// Wishbone-master sequencer for the I2C master core: programs the prescaler, then turns
// single-byte register read/write requests into TXR/CR/SR/RXR access sequences.
module i2c_wb_sequencer #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter int unsigned POLL_MAX = 1024
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i
);
    localparam int CW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR, S_STO, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic [1:0]      phase_q, phase_d;
    logic            rd_q, rd_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [CW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [1:0]      err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [2:0]      adr_q, adr_d;
    logic [7:0]      dat_q, dat_d;

    logic            acc_done;
    logic            launch_we;
    logic [2:0]      launch_adr;
    logic [7:0]      launch_dat;
    logic [7:0]      txr_byte, cr_cmd;
    logic            write_phase, last_phase;
    logic [CW-1:0]   poll_nxt;
    logic            tip, timeout;

    // NOTE: Wishbone outputs are registers, so a reset edge clears them with no comb path.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_INIT;
            init_idx_q <= 2'd0;
            phase_q    <= 2'd0;
            rd_q       <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= 8'd0;
            wdata_q    <= 8'd0;
            poll_cnt_q <= '0;
            err_q      <= 2'd0;
            rdata_q    <= 8'd0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 3'd0;
            dat_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            phase_q    <= phase_d;
            rd_q       <= rd_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        phase_d    = phase_q;
        rd_d       = rd_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        acc_done   = 1'b0;
        launch_we  = 1'b1;
        launch_adr = 3'd0;
        launch_dat = 8'h00;

        write_phase = !(rd_q && phase_q == 2'd3);
        last_phase  = rd_q ? (phase_q == 2'd3) : (phase_q == 2'd2);
        case (phase_q)
            2'd0:    txr_byte = {dev_q, 1'b0};
            2'd1:    txr_byte = reg_q;
            default: txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
        endcase
        case (phase_q)
            2'd0:    cr_cmd = 8'h90;
            2'd1:    cr_cmd = 8'h10;
            2'd2:    cr_cmd = rd_q ? 8'h90 : 8'h50;
            default: cr_cmd = 8'h68;
        endcase
        poll_nxt = poll_cnt_q + 1'b1;
        tip      = wbm_dat_i[1];
        timeout  = tip && (poll_nxt >= CW'(POLL_MAX));

        case (state_q)
            S_INIT: begin
                launch_adr = {1'b0, init_idx_q};
                launch_dat = (init_idx_q == 2'd0) ? PRESCALE[7:0] :
                             (init_idx_q == 2'd1) ? PRESCALE[15:8] : 8'h80;
            end
            S_TXR:  begin launch_adr = 3'd3; launch_dat = txr_byte; end
            S_CR:   begin launch_adr = 3'd4; launch_dat = cr_cmd;   end
            S_POLL: begin launch_we = 1'b0; launch_adr = 3'd4;      end
            S_RXR:  begin launch_we = 1'b0; launch_adr = 3'd3;      end
            S_STO:  begin launch_adr = 3'd4; launch_dat = 8'h40;    end
            default: ;
        endcase

        // Launching only from cyc=0 guarantees the idle cycle between accesses.
        if (state_q inside {S_INIT, S_TXR, S_CR, S_POLL, S_RXR, S_STO}) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                we_d  = launch_we;
                adr_d = launch_adr;
                dat_d = launch_dat;
            end else if (wbm_ack_i) begin
                cyc_d    = 1'b0;
                we_d     = 1'b0;
                adr_d    = 3'd0;
                dat_d    = 8'h00;
                acc_done = 1'b1;
            end
        end

        case (state_q)
            S_INIT: if (acc_done) begin
                if (init_idx_q == 2'd2) state_d = S_IDLE;
                else init_idx_d = init_idx_q + 2'd1;
            end
            S_IDLE: if (req_valid) begin
                rd_d    = req_rd;
                dev_d   = req_dev;
                reg_d   = req_reg;
                wdata_d = req_wdata;
                phase_d = 2'd0;
                err_d   = 2'd0;
                rdata_d = 8'h00;
                state_d = S_TXR;
            end
            S_TXR: if (acc_done) state_d = S_CR;
            S_CR: if (acc_done) begin
                poll_cnt_d = '0;
                state_d    = S_POLL;
            end
            S_POLL: if (acc_done) begin
                poll_cnt_d = poll_nxt;
                if (!tip || timeout) begin
                    if (wbm_dat_i[5]) begin
                        err_d   = 2'd2;
                        state_d = S_DONE;
                    end else if (timeout) begin
                        err_d   = 2'd3;
                        state_d = S_STO;
                    end else if (wbm_dat_i[7] && write_phase) begin
                        err_d   = 2'd1;
                        state_d = S_STO;
                    end else if (last_phase) begin
                        state_d = rd_q ? S_RXR : S_DONE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        state_d = (rd_q && phase_q == 2'd2) ? S_CR : S_TXR;
                    end
                end
            end
            S_RXR: if (acc_done) begin
                rdata_d = wbm_dat_i;
                state_d = S_DONE;
            end
            S_STO: if (acc_done) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
endmodule
